// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the two-port program ROM arbiter.
package rom_arb_pkg;
    localparam int ROM_AW = 13;
    localparam int ROM_DW = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic {
        ARB_RR   = 1'b0,
        ARB_PRIO = 1'b1
    } arb_mode_t;
endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner select for the two ROM requesters.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  arb_mode_t  i_mode,
    input  logic       i_last_grant,
    input  logic       i_starved,
    output logic       o_gnt_v,
    output logic       o_gnt_idx
);
    always_comb begin
        o_gnt_v   = |i_req;
        o_gnt_idx = PORT_CPU;
        if (i_req == 2'b11) begin
            // Round-robin hands a conflict to whoever did not win last time
            if (i_mode == ARB_RR) o_gnt_idx = ~i_last_grant;
            else                  o_gnt_idx = i_starved ? PORT_DBG : PORT_CPU;
        end else if (i_req[1]) begin
            o_gnt_idx = PORT_DBG;
        end
    end
endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous ROM port between the CPU fetch path (port 0) and the
// debug reader (port 1); one issue per clk, response routed back by a 1-deep tag.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW         = ROM_AW,
    parameter int DW         = ROM_DW,
    parameter int MODE       = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_ack,
    output logic          p0_valid,
    output logic [DW-1:0] p0_data,
    input  logic          p1_req,
    input  logic [AW-1:0] p1_addr,
    output logic          p1_ack,
    output logic          p1_valid,
    output logic [DW-1:0] p1_data,
    output logic [AW-1:0] rom_a,
    output logic          rom_ce,
    output logic          rom_oe,
    input  logic [DW-1:0] rom_d
);
    localparam int        SW     = $clog2(STARVE_MAX + 1);
    localparam arb_mode_t L_MODE = (MODE == 0) ? ARB_RR : ARB_PRIO;

    logic [AW-1:0] r_rom_a;
    logic          r_rom_ce;
    logic          r_rom_oe;
    logic [1:0]    r_ack;
    logic [1:0]    r_valid;
    logic          r_tag_v;
    logic          r_tag;
    logic          r_last_grant;
    logic [SW-1:0] r_starve;

    logic [1:0]    w_req;
    logic          w_gnt_v;
    logic          w_gnt_idx;
    logic          w_starved;
    logic          w_p1_lost;

    assign w_req     = {p1_req, p0_req};
    assign w_starved = (r_starve == SW'(STARVE_MAX));
    assign w_p1_lost = (w_req == 2'b11) && (w_gnt_idx == PORT_CPU);

    rom_arb_pick u_pick (
        .i_req        (w_req),
        .i_mode       (L_MODE),
        .i_last_grant (r_last_grant),
        .i_starved    (w_starved),
        .o_gnt_v      (w_gnt_v),
        .o_gnt_idx    (w_gnt_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_a      <= '0;
            r_rom_ce     <= 1'b0;
            r_rom_oe     <= 1'b0;
            r_ack        <= 2'b00;
            r_valid      <= 2'b00;
            r_tag_v      <= 1'b0;
            r_tag        <= PORT_CPU;
            r_last_grant <= PORT_DBG;
            r_starve     <= '0;
        end else begin
            r_rom_oe <= 1'b1;
            r_rom_ce <= w_gnt_v;
            r_ack    <= w_gnt_v ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;
            r_tag_v  <= w_gnt_v;
            r_tag    <= w_gnt_idx;
            // The ROM answers one cycle after rom_ce, exactly when the tag is here
            r_valid  <= {r_tag_v & r_tag, r_tag_v & ~r_tag};
            if (w_gnt_v) begin
                r_rom_a      <= w_gnt_idx ? p1_addr : p0_addr;
                r_last_grant <= w_gnt_idx;
            end
            if (!p1_req || (w_gnt_v && w_gnt_idx == PORT_DBG))
                r_starve <= '0;
            else if (w_p1_lost && !w_starved)
                r_starve <= r_starve + SW'(1);
        end
    end

    assign rom_a    = r_rom_a;
    assign rom_ce   = r_rom_ce;
    assign rom_oe   = r_rom_oe;
    assign p0_ack   = r_ack[0];
    assign p1_ack   = r_ack[1];
    assign p0_valid = r_valid[0];
    assign p1_valid = r_valid[1];
    assign p0_data  = r_valid[0] ? rom_d : '0;
    assign p1_data  = r_valid[1] ? rom_d : '0;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench: MODE 0 and MODE 1 arbiters driven by the same requesters,
// each with its own ROM model returning addr[7:0] ^ addr[12:8] ^ 8'hFC.
module tb_rom_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p1_req;
    logic [12:0] p0_addr, p1_addr;

    logic [1:0]  ack_m [2];
    logic [1:0]  vld_m [2];
    logic [7:0]  d0_m  [2];
    logic [7:0]  d1_m  [2];
    logic [12:0] a_m   [2];
    logic        ce_m  [2];
    logic        oe_m  [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gd
        logic        p0_ack, p0_valid, p1_ack, p1_valid, rom_ce, rom_oe;
        logic [7:0]  p0_data, p1_data, rom_d;
        logic [12:0] rom_a;

        rom_port_arbiter #(.AW(13), .DW(8), .MODE(g), .STARVE_MAX(4)) dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .p0_req   (p0_req),
            .p0_addr  (p0_addr),
            .p0_ack   (p0_ack),
            .p0_valid (p0_valid),
            .p0_data  (p0_data),
            .p1_req   (p1_req),
            .p1_addr  (p1_addr),
            .p1_ack   (p1_ack),
            .p1_valid (p1_valid),
            .p1_data  (p1_data),
            .rom_a    (rom_a),
            .rom_ce   (rom_ce),
            .rom_oe   (rom_oe),
            .rom_d    (rom_d)
        );

        always @(posedge clk)
            if (rom_ce) rom_d <= rom_a[7:0] ^ {3'b000, rom_a[12:8]} ^ 8'hFC;

        assign ack_m[g] = {p1_ack, p0_ack};
        assign vld_m[g] = {p1_valid, p0_valid};
        assign d0_m[g]  = p0_data;
        assign d1_m[g]  = p1_data;
        assign a_m[g]   = rom_a;
        assign ce_m[g]  = rom_ce;
        assign oe_m[g]  = rom_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk(input int m);
        chk($sformatf("rst_ctl m%0d", m), {ack_m[m], vld_m[m], ce_m[m], oe_m[m], a_m[m]}, 32'h0);
        chk($sformatf("rst_data m%0d", m), {d1_m[m], d0_m[m]}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat [2];
        logic [7:0] b2b [8];
        logic       g, pg;
        pat[0] = 10'h2AA;  // MODE 0: p0,p1,p0,... (bit set = p1 granted)
        pat[1] = 10'h210;  // MODE 1: p0 x4, p1, p0 x4, p1
        b2b = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hF8, 8'hF9, 8'hFA, 8'hFB};

        reset_n = 1'b0;
        p0_req = 1'b0; p1_req = 1'b0;
        p0_addr = 'x;  p1_addr = 'x;
        repeat (2) tick();
        for (int m = 0; m < 2; m++) rst_chk(m);
        reset_n = 1'b1;

        // Idle, X addresses must not reach rom_a
        for (int i = 0; i < 10; i++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("idle_ctl m%0d c%0d", m, i), {ack_m[m], vld_m[m], ce_m[m]}, 32'h0);
                chk($sformatf("idle_a m%0d c%0d", m, i), a_m[m], 32'h0);
                chk($sformatf("idle_oe m%0d c%0d", m, i), oe_m[m], 32'h1);
            end
        end

        // Single read on port 0
        p0_req = 1'b1; p0_addr = 13'h1ABC;
        tick();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("single_ack m%0d", m), ack_m[m], 32'h1);
            chk($sformatf("single_a m%0d", m), a_m[m], 32'h1ABC);
            chk($sformatf("single_ce m%0d", m), ce_m[m], 32'h1);
            chk($sformatf("single_vld0 m%0d", m), vld_m[m], 32'h0);
        end
        p0_req = 1'b0; p0_addr = 'x;
        tick();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("single_vld m%0d", m), {ack_m[m], vld_m[m], ce_m[m]}, 32'b00_01_0);
            chk($sformatf("single_data m%0d", m), {d1_m[m], d0_m[m]}, 32'h005A);
        end
        tick();
        for (int m = 0; m < 2; m++)
            chk($sformatf("single_end m%0d", m), {vld_m[m], d0_m[m]}, 32'h0);

        // Fresh reset so port 0 wins the first conflict again
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Sustained conflict: alternating (MODE 0) and starvation guard (MODE 1)
        p0_req = 1'b1; p1_req = 1'b1;
        p0_addr = 13'h0010; p1_addr = 13'h1FFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                g = pat[m][i];
                chk($sformatf("cf_ack m%0d c%0d", m, i), ack_m[m], g ? 32'h2 : 32'h1);
                chk($sformatf("cf_a m%0d c%0d", m, i), a_m[m], g ? 32'h1FFF : 32'h0010);
                if (i > 0) begin
                    pg = pat[m][i-1];
                    chk($sformatf("cf_vld m%0d c%0d", m, i), vld_m[m], pg ? 32'h2 : 32'h1);
                    chk($sformatf("cf_data m%0d c%0d", m, i), {d1_m[m], d0_m[m]},
                        pg ? 32'h1C00 : 32'h00EC);
                end
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("cf_tail_ack m%0d", m), ack_m[m], 32'h0);
            chk($sformatf("cf_tail m%0d", m), {vld_m[m], d1_m[m], d0_m[m]}, 32'h21C00);
        end
        tick();

        // Back-to-back stream on port 0
        p0_req = 1'b1; p0_addr = 13'h0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("b2b_ack m%0d c%0d", m, i), ack_m[m], 32'h1);
                chk($sformatf("b2b_a m%0d c%0d", m, i), a_m[m], i);
                if (i > 0) begin
                    chk($sformatf("b2b_vld m%0d c%0d", m, i), vld_m[m], 32'h1);
                    chk($sformatf("b2b_data m%0d c%0d", m, i), d0_m[m], b2b[i-1]);
                end
            end
            if (i == 7) p0_req = 1'b0;
            p0_addr = 13'(i + 1);
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("b2b_last m%0d", m), {ack_m[m], vld_m[m], d0_m[m]}, 32'h1FB);
        end
        tick();
        for (int m = 0; m < 2; m++)
            chk($sformatf("b2b_end m%0d", m), vld_m[m], 32'h0);

        // Reset while a port-1 response is on the bus
        p1_req = 1'b1; p1_addr = 13'h0123;
        tick();
        for (int m = 0; m < 2; m++)
            chk($sformatf("mid_ack m%0d", m), ack_m[m], 32'h2);
        p1_req = 1'b0; p1_addr = 'x;
        tick();
        for (int m = 0; m < 2; m++)
            chk($sformatf("mid_vld m%0d", m), {vld_m[m], d1_m[m]}, 32'h2DE);
        reset_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) rst_chk(m);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("post_rst m%0d c%0d", m, i), {ack_m[m], vld_m[m], ce_m[m]}, 32'h0);
                chk($sformatf("post_oe m%0d c%0d", m, i), oe_m[m], 32'h1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
